// File: rtl/cache_mem_ctrl.sv
// cache_mem_ctrl: serialises 128-bit line fills/write-backs into four 32-bit req/ack word-bus beats
module cache_mem_ctrl #(
  parameter int LINE_WORDS = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         req_valid_i,
  input  logic         req_rw_i,
  input  logic [31:0]  req_addr_i,
  input  logic [127:0] req_data_i,
  output logic         res_ready_o,
  output logic [127:0] res_data_o,
  output logic         bus_req_o,
  output logic         bus_we_o,
  output logic [31:0]  bus_addr_o,
  output logic [31:0]  bus_wdata_o,
  input  logic         bus_ack_i,
  input  logic [31:0]  bus_rdata_i,
  output logic         busy_o,
  output logic [31:0]  rd_cnt_o,
  output logic [31:0]  wr_cnt_o
);
  typedef enum logic [1:0] {IDLE, BURST, RESP} state_t;
  state_t state, state_n;
  logic [1:0]   beat;
  logic [27:0]  addr_q;
  logic         rw_q;
  logic [127:0] data_q, line_q;
  logic [31:0]  rd_cnt, wr_cnt;
  logic         last_beat;
  logic         unused_addr;
  assign unused_addr = ^req_addr_i[3:0];
  assign last_beat = beat == 2'(LINE_WORDS - 1);
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    state_n = state == IDLE  ? (req_valid_i ? BURST : IDLE) :
              state == BURST ? (bus_ack_i && last_beat ? RESP : BURST) : IDLE;
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      beat   <= '0;
      addr_q <= '0;
      rw_q   <= 1'b0;
      data_q <= '0;
      line_q <= '0;
      rd_cnt <= '0;
      wr_cnt <= '0;
    end else begin
      if (state == IDLE && req_valid_i) begin
        addr_q <= req_addr_i[31:4];
        rw_q   <= req_rw_i;
        data_q <= req_data_i;
        beat   <= '0;
      end
      if (state == BURST && bus_ack_i) begin
        beat <= beat + 2'd1;
        if (!rw_q) line_q[{beat, 5'd0} +: 32] <= bus_rdata_i;
      end
      if (state == RESP) begin
        if (rw_q) wr_cnt <= wr_cnt + 32'd1;
        else rd_cnt <= rd_cnt + 32'd1;
      end
    end
  assign bus_req_o   = state == BURST;
  assign bus_we_o    = bus_req_o & rw_q;
  assign bus_addr_o  = bus_req_o ? {addr_q, beat, 2'b00} : '0;
  assign bus_wdata_o = bus_req_o ? data_q[{beat, 5'd0} +: 32] : '0;
  assign res_ready_o = state == RESP;
  assign res_data_o  = line_q;
  assign busy_o      = state != IDLE;
  assign rd_cnt_o    = rd_cnt;
  assign wr_cnt_o    = wr_cnt;
endmodule

// File: tb/tb_cache_mem_ctrl.sv
// tb_cache_mem_ctrl: directed checks of fills, write-backs, stalls, back-to-back requests and mid-burst reset
module tb_cache_mem_ctrl;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req_valid = 1'b0, req_rw = 1'b0;
  logic [31:0]  req_addr = '0;
  logic [127:0] req_data = '0;
  logic         res_ready;
  logic [127:0] res_data;
  logic         bus_req, bus_we;
  logic [31:0]  bus_addr, bus_wdata;
  logic         bus_ack = 1'b0;
  logic [31:0]  bus_rdata = '0;
  logic         busy;
  logic [31:0]  rd_cnt, wr_cnt;
  int total = 0, bad = 0, pulses = 0, p0;

  cache_mem_ctrl dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_rw_i(req_rw), .req_addr_i(req_addr), .req_data_i(req_data),
    .res_ready_o(res_ready), .res_data_o(res_data),
    .bus_req_o(bus_req), .bus_we_o(bus_we), .bus_addr_o(bus_addr), .bus_wdata_o(bus_wdata),
    .bus_ack_i(bus_ack), .bus_rdata_i(bus_rdata),
    .busy_o(busy), .rd_cnt_o(rd_cnt), .wr_cnt_o(wr_cnt)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (res_ready) pulses++;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_req"}, bus_req, 0);
    chk({tag, "_we"}, bus_we, 0);
    chk({tag, "_addr"}, bus_addr, 0);
    chk({tag, "_wdata"}, bus_wdata, 0);
    chk({tag, "_ready"}, res_ready, 0);
    chk({tag, "_rdata"}, res_data, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_rdcnt"}, rd_cnt, 0);
    chk({tag, "_wrcnt"}, wr_cnt, 0);
  endtask

  task automatic txn(input string tag, input logic rw, input logic [31:0] addr, input logic [127:0] wd,
                     input logic [127:0] rd, input logic [127:0] exp_line, input int stall_beat,
                     input int stalls, input int exp_lat, input bit hold);
    int lat = 0, b = 0, st = 0;
    bit done = 0;
    req_valid = 1'b1; req_rw = rw; req_addr = addr; req_data = wd;
    while (!done && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      bus_ack = 1'b0;
      if (lat == 2) begin req_addr = ~addr; req_rw = ~rw; req_data = ~wd; end
      if (res_ready) begin
        done = 1;
        chk({tag, "_lat"}, 128'(lat), 128'(exp_lat));
        chk({tag, "_line"}, res_data, exp_line);
        chk({tag, "_beats"}, 128'(b), 4);
      end else if (bus_req) begin
        chk({tag, "_addr"}, bus_addr, (addr & 32'hFFFF_FFF0) | 32'(b * 4));
        chk({tag, "_we"}, bus_we, rw);
        if (rw) chk({tag, "_wdata"}, bus_wdata, wd[b*32 +: 32]);
        chk({tag, "_busy"}, busy, 1);
        if (b == stall_beat && st < stalls) st++;
        else begin
          bus_ack = 1'b1;
          bus_rdata = rd[b*32 +: 32];
          b++;
        end
      end
    end
    if (!done) chk({tag, "_timeout"}, 0, 1);
    if (!hold) req_valid = 1'b0;
  endtask

  initial begin
    #3;
    chk_idle_zero("rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    txn("fill", 0, 32'h0000_1234, '0, {32'hA3, 32'hA2, 32'hA1, 32'hA0},
        {32'hA3, 32'hA2, 32'hA1, 32'hA0}, -1, 0, 5, 0);
    @(negedge clk);
    chk("fill_busy_after", busy, 0);
    chk("fill_rdcnt", rd_cnt, 1);
    chk("fill_wrcnt", wr_cnt, 0);
    txn("wb", 1, 32'h8000_0040, {32'd4, 32'd3, 32'd2, 32'd1}, {4{32'hDEAD_BEEF}},
        {32'hA3, 32'hA2, 32'hA1, 32'hA0}, -1, 0, 5, 0);
    @(negedge clk);
    chk("wb_wrcnt", wr_cnt, 1);
    chk("wb_rdcnt", rd_cnt, 1);
    chk("wb_line_kept", res_data, {32'hA3, 32'hA2, 32'hA1, 32'hA0});
    txn("stall", 0, 32'h0000_2008, '0, {32'h1333, 32'h1222, 32'h1111, 32'h1000},
        {32'h1333, 32'h1222, 32'h1111, 32'h1000}, 2, 3, 8, 0);
    @(negedge clk);
    chk("stall_rdcnt", rd_cnt, 2);
    txn("swb", 1, 32'h0000_4000, {32'hC3, 32'hC2, 32'hC1, 32'hC0}, '0,
        {32'h1333, 32'h1222, 32'h1111, 32'h1000}, 1, 2, 7, 0);
    @(negedge clk);
    chk("swb_wrcnt", wr_cnt, 2);
    req_valid = 1'b1; req_rw = 1'b0; req_addr = 32'h0000_3000;
    @(negedge clk);
    bus_ack = 1'b1; bus_rdata = 32'h55;
    @(negedge clk);
    chk("rstmid_beat1", bus_addr, 32'h0000_3004);
    bus_ack = 1'b1; bus_rdata = 32'h66;
    p0 = pulses;
    @(posedge clk);
    #2 rst_n = 1'b0;
    bus_ack = 1'b0; req_valid = 1'b0;
    #1;
    chk_idle_zero("rstmid");
    repeat (2) @(negedge clk);
    chk("rstmid_nopulse", 128'(pulses), 128'(p0));
    rst_n = 1'b1;
    @(negedge clk);
    p0 = pulses;
    txn("b2b_wb", 1, 32'h0000_5010, {32'hD3, 32'hD2, 32'hD1, 32'hD0}, '0, '0, -1, 0, 5, 1);
    txn("b2b_fill", 0, 32'h0000_6020, '0, {32'hE3, 32'hE2, 32'hE1, 32'hE0},
        {32'hE3, 32'hE2, 32'hE1, 32'hE0}, -1, 0, 6, 0);
    repeat (3) @(negedge clk);
    chk("b2b_pulses", 128'(pulses - p0), 2);
    chk("b2b_rdcnt", rd_cnt, 1);
    chk("b2b_wrcnt", wr_cnt, 1);
    chk("b2b_idle", busy, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cache_mem_ctrl.md
# cache_mem_ctrl

Line-fill/write-back memory controller directly downstream of the L2 cache FSM. It accepts one 128-bit line request from the cache (read = allocate, write = write-back of a dirty line) and serialises it into four 32-bit beats on a simple req/ack word bus to main memory. For reads, it reassembles the beats into a line, then returns a one-cycle ready pulse plus the line to the cache FSM. It also keeps read and write transaction counters for the performance-statistics path.

## Interface
Parameters:
- LINE_WORDS, 4, beats per line; fixed by the 128-bit line, other values unsupported.

Ports:
- clk_i  in  1  single clock, rising edge.
- rst_ni  in  1  asynchronous, active-low reset.
- req_valid_i  in  1  cache request valid (level, held by FSM until ready).
- req_rw_i  in  1  1 = write-back, 0 = line fill.
- req_addr_i  in  32  request address; bits [3:0] ignored.
- req_data_i  in  128  dirty line for write-back; word 0 = bits [31:0].
- res_ready_o  out  1  one-cycle completion pulse to cache FSM.
- res_data_o  out  128  last filled line.
- bus_req_o  out  1  word-bus beat request.
- bus_we_o  out  1  beat is a write.
- bus_addr_o  out  32  beat word address.
- bus_wdata_o  out  32  write beat data.
- bus_ack_i  in  1  beat accepted; read data valid in the same cycle.
- bus_rdata_i  in  32  read beat data.
- busy_o  out  1  high in any state other than IDLE.
- rd_cnt_o  out  32  completed line fills.
- wr_cnt_o  out  32  completed write-backs.

## Operation
- States: IDLE, BURST, RESP.
- IDLE:
  - If req_valid_i is high, latch addr[31:4], rw and data into internal registers, clear the beat counter, and go to BURST.
  - Otherwise stay in IDLE.
- BURST:
  - bus_req_o = 1, bus_we_o = latched rw, bus_addr_o = {addr[31:4], beat[1:0], 2'b00}.
  - bus_wdata_o = latched data word[beat], valid for both reads and writes (0 is acceptable for reads).
  - On bus_ack_i:
    - Read: store bus_rdata_i into line-buffer word[beat].
    - Increment beat.
    - If beat == 3, go to RESP.
  - If bus_ack_i is low, hold all bus outputs stable; there is no timeout.
- RESP:
  - res_ready_o = 1.
  - Increment rd_cnt_o or wr_cnt_o per the latched rw.
  - Go to IDLE.
- req_* inputs are ignored outside IDLE; changes to them mid-burst do not affect the transaction.
- A request is only ever accepted in IDLE. req_valid_i being high during RESP is not taken as a new request. If it is still (or newly) high in the following IDLE cycle, it is accepted: this covers a write-back followed by an immediate fill.
- res_data_o = the line buffer.
  - Updated only by read beats.
  - Write-backs leave it unchanged.
  - During a fill it shows a partially updated line; it is only meaningful while res_ready_o = 1.
- Counters wrap modulo 2^32 with no saturation.
- Reset values:
  - state IDLE, beat 0.
  - Line buffer 0 and latched request 0.
  - All outputs 0: bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, res_ready_o, res_data_o, busy_o, rd_cnt_o, wr_cnt_o.
- Reset asserted mid-burst aborts the transaction immediately:
  - bus_req_o drops asynchronously.
  - No res_ready_o pulse is produced.
  - Counters clear.

## Timing
- Cycle 0: IDLE samples req_valid_i = 1.
- Cycles 1..4 (with ack every cycle): BURST beats 0..3.
- Cycle 5: RESP, res_ready_o = 1.
- Cycle 6: IDLE, able to accept a new request.
- Minimum latency from valid to ready is 5 cycles; each extra cycle with ack low adds one cycle.
- All outputs are registered-state decodes: bus_* and res_ready_o are combinational from state/beat/latched registers, never from req_* inputs in the same cycle.
- The counter increment is visible on rd_cnt_o / wr_cnt_o in the cycle after RESP.
- busy_o = 1 from cycle 1 through RESP inclusive.

## Test plan
- Line fill:
  - Stimulus: req_valid_i = 1, rw = 0, addr 0x0000_1234; bus acks every cycle, rdata = 0xA0, 0xA1, 0xA2, 0xA3.
  - Required: bus_addr_o = 0x1230, 0x1234, 0x1238, 0x123C; res_ready_o pulses once at cycle 5 with res_data_o = {0xA3, 0xA2, 0xA1, 0xA0}; rd_cnt_o = 1.
- Write-back:
  - Stimulus: rw = 1, addr 0x8000_0040, data {4, 3, 2, 1}.
  - Required: bus_we_o = 1 with wdata 1, 2, 3, 4 at 0x8000_0040..4C; res_data_o unchanged from the prior fill; wr_cnt_o = 1.
- Stalls:
  - Stimulus: bus_ack_i low for 3 cycles before beat 2.
  - Required: bus_addr_o and bus_wdata_o stay constant while ack is low; ready arrives at cycle 8.
- Back-to-back write-back then fill:
  - Stimulus: req_valid_i held high, rw switches 1 → 0 in the cycle after RESP.
  - Required: exactly two ready pulses; the fill starts in the cycle after RESP; counters rd = 1, wr = 1.
- Mid-burst input change:
  - Stimulus: req_addr_i and req_rw_i change during BURST.
  - Required: bus addresses and direction follow the latched values.
- Reset mid-burst:
  - Stimulus: rst_ni low after beat 1.
  - Required: bus_req_o = 0 immediately; all outputs 0; no ready pulse; the next request after release completes normally.
